pipeline_hazard_ctrl: RTL

- Central sequencer for the 5-stage pipeline's stage registers.
- Generates freeze and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers from three sources: load-use/data hazards, taken branches in EX, and multi-cycle memory accesses in MEM.
- Owns the request/ready handshake to the SRAM/cache controller, including a timeout watchdog and saturating performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: freeze/flush sequencer for a 5-stage pipeline with memory handshake, watchdog and perf counters
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   src1_i/src2_i (+_valid_i)     : ID-stage source registers
//   forward_en_i                  : forwarding unit active
//   exe_wb_en_i/exe_mem_read_i/exe_dest_i : EX-stage writeback info
//   mem_wb_en_i/mem_dest_i        : MEM-stage writeback info
//   branch_taken_i                : EX branch resolved taken
//   mem_req_i/mem_ready_i         : MEM-stage access request / controller completion
//   cnt_clr_i                     : clear performance counters
//   mem_go_o                      : start pulse to memory controller
//   freeze_*_o / flush_*_o        : stage register controls
//   mem_timeout_o                 : sticky watchdog error
//   stall_cycles_o/flush_count_o  : saturating performance counters
module pipeline_hazard_ctrl #(
    parameter int REG_AW  = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] src1_i,
    input  logic [REG_AW-1:0] src2_i,
    input  logic              src1_valid_i,
    input  logic              src2_valid_i,
    input  logic              forward_en_i,
    input  logic              exe_wb_en_i,
    input  logic              exe_mem_read_i,
    input  logic [REG_AW-1:0] exe_dest_i,
    input  logic              mem_wb_en_i,
    input  logic [REG_AW-1:0] mem_dest_i,
    input  logic              branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    input  logic              cnt_clr_i,
    output logic              mem_go_o,
    output logic              freeze_pc_o,
    output logic              freeze_if_id_o,
    output logic              freeze_id_ex_o,
    output logic              freeze_back_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              mem_timeout_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  flush_count_o
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    state_t             state_q, state_d;
    logic [15:0]        wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
    logic               mem_stall, hz1, hz2, hazard, hold_all, do_flush, do_bubble;
    // With forwarding only a load in EX can't be bypassed; MEM results always forward.
    assign hz1 = src1_valid_i & (forward_en_i ? (exe_wb_en_i & exe_mem_read_i & (exe_dest_i == src1_i))
                                              : ((exe_wb_en_i & (exe_dest_i == src1_i)) | (mem_wb_en_i & (mem_dest_i == src1_i))));
    assign hz2 = src2_valid_i & (forward_en_i ? (exe_wb_en_i & exe_mem_read_i & (exe_dest_i == src2_i))
                                              : ((exe_wb_en_i & (exe_dest_i == src2_i)) | (mem_wb_en_i & (mem_dest_i == src2_i))));
    assign hazard    = hz1 | hz2;
    assign mem_stall = (state_q == RUN) ? (mem_req_i & ~mem_ready_i) : (state_q == MEM_WAIT) & ~mem_ready_i;
    // A branch seen during a stall is simply not acted on; EX is frozen so it resurfaces afterwards.
    assign hold_all  = ~rst & ((state_q == ERR) | mem_stall);
    assign do_flush  = ~rst & ~hold_all & branch_taken_i;
    assign do_bubble = ~rst & ~hold_all & ~branch_taken_i & hazard;
    assign mem_go_o       = ~rst & (state_q == RUN) & mem_req_i;
    assign freeze_pc_o    = hold_all | do_bubble;
    assign freeze_if_id_o = hold_all | do_bubble;
    assign freeze_id_ex_o = hold_all;
    assign freeze_back_o  = hold_all;
    assign flush_if_id_o  = do_flush;
    assign flush_id_ex_o  = do_flush | do_bubble;
    assign mem_timeout_o  = ~rst & (state_q == ERR);
    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: if (mem_req_i & ~mem_ready_i) begin
                state_d    = MEM_WAIT;
                wait_cnt_d = '0;
            end
            MEM_WAIT: if (mem_ready_i) state_d = RUN;
                else if (wait_cnt_q == WAIT_LAST) state_d = ERR;
                else wait_cnt_d = wait_cnt_q + 16'd1;
            default: state_d = ERR;
        endcase
        stall_cycles_d = cnt_clr_i ? '0 : (freeze_pc_o & ~&stall_cycles_q) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
        flush_count_d  = cnt_clr_i ? '0 : (flush_if_id_o & ~&flush_count_q) ? flush_count_q + CNT_W'(1) : flush_count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end
endmodule
